// File: rtl/mem_drain.sv
`default_nettype none
// mem_drain: drains DEPTH samples from a synchronous-read memory into a stream
// through a 2-entry FIFO, summing the sign-extended samples it hands over.
module mem_drain #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [AW-1:0]     rd_addr,
  output logic              rd_en,
  input  logic [DW-1:0]     rd_data,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DW+AW-1:0]  checksum,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0]    IDLE      = 2'd0;
  localparam logic [1:0]    RUN       = 2'd1;
  localparam logic [1:0]    FLUSH     = 2'd2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic          inflight;
  logic          inflight_last;
  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          pop;
  logic          push;
  logic          issue;
  logic          start_ok;
  logic [1:0]    committed;

  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  // Slots already spoken for once this cycle's pop is taken into account;
  // issuing only when at most one is taken keeps the 2-entry FIFO from overflowing.
  assign committed = count + {1'b0, inflight} - {1'b0, pop};
  assign issue     = (state == RUN) && (committed <= 2'd1);
  assign rd_en     = issue;

  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign busy      = (state != IDLE);
  assign start_ok  = start & (state == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rd_addr <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            rd_addr <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            // The address parks on the last location so it never wraps.
            if (rd_addr == LAST_ADDR) begin
              state <= FLUSH;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
        end
        FLUSH: begin
          if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (rd_addr == LAST_ADDR);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rd_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + {{AW{out_data[DW-1]}}, out_data};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_drain.sv
`default_nettype none
// tb_mem_drain: drives directed and randomized runs; the k-th transfer of a run
// is expected to equal mem[k] and the checksum the signed sum of the memory.
module tb_mem_drain;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int CW    = DW + AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic [CW-1:0] checksum;
  logic          busy;
  logic          done;

  mem_drain #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .checksum(checksum), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;
  int exp_addr = 0, issued = 0, xfers = 0, dones = 0, last_xfer_cyc = 0;
  logic [CW-1:0] run_sum = '0;
  logic [CW-1:0] exp_ck = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: tracks run progress at each falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) check("ck_track", 32'(checksum), 32'(run_sum));
      check("occupancy_le2", 32'((issued - xfers) <= 2), 32'd1);
      if (rd_en) begin
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        check("no_extra_read", 32'(exp_addr < DEPTH), 32'd1);
        exp_addr++;
        issued++;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        check("xfer_in_range", 32'(xfers < DEPTH), 32'd1);
        check("data", 32'(out_data), 32'(mem[xfers % DEPTH]));
        check("last", 32'(out_last), 32'(xfers == DEPTH - 1));
        run_sum = run_sum + CW'($signed(out_data));
        xfers++;
        last_xfer_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        dones++;
        check("done_busy", 32'(busy), 32'd0);
        check("done_count", 32'(xfers), 32'(DEPTH));
        check("done_timing", 32'(cyc - last_xfer_cyc), 32'd1);
        check("done_ck", 32'(checksum), 32'(exp_ck));
      end
      if (start && !busy) begin
        exp_addr = 0;
        issued   = 0;
        xfers    = 0;
        run_sum  = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic fill(input int kind);
    int s;
    s = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (kind == 0)      mem[i] = DW'(i);
      else if (kind == 1) mem[i] = 8'h80;
      else                mem[i] = DW'($urandom);
      s += int'($signed(mem[i]));
    end
    exp_ck = CW'(s);
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = dones;
    n = 0;
    while (dones == d0 && n < 6000) begin
      step();
      n++;
    end
    check(tag, 32'(dones), 32'(d0 + 1));
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfers < target && n < 6000) begin
      step();
      n++;
    end
    check("reach_xfers", 32'(xfers >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_ck"}, 32'(checksum), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b1;
    mode = 0;
    repeat (4) step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rd_en", 32'(rd_en), 32'd0);

    // Ramp memory, sink always ready: latency and full stream.
    start_run();
    @(negedge clk);
    check("lat_rd_en_t1", 32'(rd_en), 32'd1);
    check("lat_valid_t1", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("lat_valid_t2", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    check("lat_valid_t3", 32'(out_valid), 32'd1);
    check("lat_data_t3", 32'(out_data), 32'd0);
    wait_done("done_ramp");
    check("ck_ramp", 32'(checksum), 32'h3FE00);
    repeat (5) step();
    check("ck_ramp_stable", 32'(checksum), 32'h3FE00);
    check("ramp_idle", 32'(busy), 32'd0);

    // Same memory with the sink toggling every cycle.
    mode = 1;
    start_run();
    wait_done("done_toggle");
    check("ck_toggle", 32'(checksum), 32'h3FE00);

    // All 0x80 with a random sink: exactly one done pulse.
    fill(1);
    mode = 2;
    d0 = dones;
    start_run();
    wait_done("done_neg");
    repeat (20) step();
    check("neg_one_done", 32'(dones), 32'(d0 + 1));
    check("ck_neg", 32'(checksum), 32'h20000);

    // Random memory, start re-pulsed mid-run is ignored.
    fill(2);
    mode = 0;
    start_run();
    wait_xfers(500);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_ignored_busy", 32'(busy), 32'd1);
    wait_done("done_restart");
    check("ck_restart", 32'(checksum), 32'(exp_ck));

    // Reset mid-run, then a fresh run from address 0.
    mode = 2;
    start_run();
    wait_xfers(300);
    d0 = dones;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    check("midrst_done1", 32'(done), 32'd0);
    step();
    check("midrst_done2", 32'(done), 32'd0);
    check_reset_outputs("midrst_hold");
    reset = 1'b1;
    repeat (5) step();
    check("postrst_busy", 32'(busy), 32'd0);
    check("postrst_rd_en", 32'(rd_en), 32'd0);
    check("postrst_no_done", 32'(dones), 32'(d0));
    start_run();
    wait_done("done_after_rst");
    check("ck_after_rst", 32'(checksum), 32'(exp_ck));

    // Sink stalled for 50 cycles at run start.
    fill(0);
    mode = 3;
    start_run();
    repeat (50) step();
    check("stall_reads", 32'(issued), 32'd2);
    check("stall_valid", 32'(out_valid), 32'd1);
    mode = 0;
    wait_done("done_stall");
    check("ck_stall", 32'(checksum), 32'h3FE00);

    // Start arriving in the done cycle is accepted.
    fill(2);
    start_run();
    wait_xfers(DEPTH);
    d0 = dones;
    start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_done_seen", 32'(dones), 32'(d0 + 1));
    check("b2b_accepted", 32'(busy), 32'd1);
    wait_done("done_b2b");
    check("ck_b2b", 32'(checksum), 32'(exp_ck));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
